// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 x WIDTH registers with r0 hardwired to
// zero, two combinational read ports with same-cycle write bypass, a
// saturating count of retired writes, and an end-of-program dump sequencer
// that streams every register out once before parking in DONE.
module wb_regfile #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_in,
  input  logic             mem_r_in,
  input  logic [WIDTH-1:0] mem_result_in,
  input  logic [WIDTH-1:0] alu_result_in,
  input  logic [4:0]       reg_dest_in,
  input  logic             terminate_in,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_en,
  output logic             dump_valid,
  output logic [4:0]       dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_regs [32];
  logic [4:0]       r_dump_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             w_wb_en;
  logic [WIDTH-1:0] w_wb_data;

  // Write-back value and the qualified strobe. The strobe is gated by rst and
  // by the RUN state so neither a reset edge nor the dump phase can write.
  assign w_wb_data = mem_r_in ? mem_result_in : alu_result_in;
  assign w_wb_en   = wb_in && (reg_dest_in != 5'd0) && (r_state == S_RUN) && !rst;

  assign wb_data = w_wb_data;
  assign wb_en   = w_wb_en;
  assign retired = r_retired;

  // Read port: r0 reads zero, a write in flight to the same register is
  // forwarded, otherwise the stored value. w_wb_en is already low outside
  // RUN, so the bypass is naturally disabled during DUMP and DONE.
  function automatic logic [WIDTH-1:0] f_read(input logic [4:0] addr);
    if (addr == 5'd0)
      return '0;
    else if (w_wb_en && (addr == reg_dest_in))
      return w_wb_data;
    else
      return r_regs[addr];
  endfunction

  // Combinational read ports A and B
  always_comb begin
    rs_data = f_read(rs_addr);
    rt_data = f_read(rt_addr);
  end

  // Register array: cleared on reset, one write per cycle. r0 is never
  // written because w_wb_en excludes destination 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[reg_dest_in] <= w_wb_data;
    end
  end

  // Retired-write counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst)
      r_retired <= '0;
    else if (w_wb_en && (r_retired != '1))
      r_retired <= r_retired + CNT_W'(1);
  end

  // Dump beat index: counts 0..31 while dumping, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst)
      r_dump_cnt <= 5'd0;
    else if (r_state == S_DUMP)
      r_dump_cnt <= r_dump_cnt + 5'd1;
    else
      r_dump_cnt <= 5'd0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_RUN;
    else
      r_state <= w_state_next;
  end

  // FSM next-state logic: terminate starts the dump, the last beat ends it
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (terminate_in) w_state_next = S_DUMP;
      S_DUMP:  if (r_dump_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_RUN;
    endcase
  end

  // FSM outputs: dump beat fields are zeroed whenever no beat is valid
  always_comb begin
    dump_valid = (r_state == S_DUMP);
    done       = (r_state == S_DONE);
    dump_addr  = 5'd0;
    dump_data  = '0;
    if (r_state == S_DUMP) begin
      dump_addr = r_dump_cnt;
      dump_data = r_regs[r_dump_cnt];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// write/read traffic checked against an array-based reference model.
module tb_wb_regfile;

  localparam int CW   = 4;            // small counter so saturation is reachable
  localparam int RMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_in;
  logic          mem_r_in;
  logic [31:0]   mem_result_in;
  logic [31:0]   alu_result_in;
  logic [4:0]    reg_dest_in;
  logic          terminate_in;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic [31:0]   wb_data;
  logic          wb_en;
  logic          dump_valid;
  logic [4:0]    dump_addr;
  logic [31:0]   dump_data;
  logic          done;
  logic [CW-1:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, phase (0 run, 1 dump, 2 done),
  // current dump beat and retired count.
  logic [31:0] m_regs [32];
  int          m_state;
  int          m_beat;
  int          m_ret;

  wb_regfile #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .mem_r_in(mem_r_in),
    .mem_result_in(mem_result_in), .alu_result_in(alu_result_in),
    .reg_dest_in(reg_dest_in), .terminate_in(terminate_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_en(wb_en), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_wben();
    return wb_in && (reg_dest_in != 5'd0) && (m_state == 0) && !rst;
  endfunction

  function automatic logic [31:0] exp_wbdata();
    return mem_r_in ? mem_result_in : alu_result_in;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (exp_wben() && a == reg_dest_in) return exp_wbdata();
    return m_regs[a];
  endfunction

  task automatic idle();
    wb_in = 1'b0; mem_r_in = 1'b0; mem_result_in = '0; alu_result_in = '0;
    reg_dest_in = '0; terminate_in = 1'b0;
  endtask

  // Advance the model by the rules for the inputs now applied, then clock.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_state = 0; m_beat = 0; m_ret = 0;
    end else if (m_state == 0) begin
      if (wb_in && reg_dest_in != 5'd0) begin
        m_regs[reg_dest_in] = exp_wbdata();
        if (m_ret < RMAX) m_ret++;
      end
      if (terminate_in) begin m_state = 1; m_beat = 0; end
    end else if (m_state == 1) begin
      if (m_beat == 31) m_state = 2; else m_beat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wb_in = 1'b1; reg_dest_in = 5'd5; alu_result_in = 32'h5555;
    terminate_in = 1'b1; #1;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wben: got %b expected 0", wb_en); end
    tick(); tick(); rst = 1'b0; idle(); rs_addr = 5'd5; rt_addr = 5'd0; #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL reset_rs: got %h expected 0", rs_data); end
    n_cmp++; if (rt_data !== 32'h0) begin n_err++; $display("FAIL reset_rt: got %h expected 0", rt_data); end
    n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL reset_dump_valid: got %b expected 0", dump_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (retired !== '0) begin n_err++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    $display("test_reset: finished");
  endtask

  task automatic test_write_alu();
    idle(); wb_in = 1'b1; alu_result_in = 32'h1234; reg_dest_in = 5'd5; #1;
    n_cmp++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL alu_wben: got %b expected 1", wb_en); end
    n_cmp++; if (wb_data !== 32'h1234) begin n_err++; $display("FAIL alu_wbdata: got %h expected 1234", wb_data); end
    tick(); idle(); rs_addr = 5'd5; #1;
    n_cmp++; if (rs_data !== 32'h1234) begin n_err++; $display("FAIL alu_read_r5: got %h expected 1234", rs_data); end
    n_cmp++; if (retired !== CW'(1)) begin n_err++; $display("FAIL alu_retired: got %0d expected 1", retired); end
    $display("test_write_alu: finished");
  endtask

  task automatic test_load_select();
    idle(); wb_in = 1'b1; mem_r_in = 1'b1; mem_result_in = 32'hDEADBEEF;
    alu_result_in = 32'h1; reg_dest_in = 5'd7; #1;
    n_cmp++; if (wb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_wbdata: got %h expected deadbeef", wb_data); end
    tick(); idle(); rt_addr = 5'd7; #1;
    n_cmp++; if (rt_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_read_r7: got %h expected deadbeef", rt_data); end
    n_cmp++; if (retired !== CW'(2)) begin n_err++; $display("FAIL load_retired: got %0d expected 2", retired); end
    $display("test_load_select: finished");
  endtask

  task automatic test_r0_write();
    idle(); wb_in = 1'b1; reg_dest_in = 5'd0; alu_result_in = 32'hFFFF; rs_addr = 5'd0; #1;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL r0_wben: got %b expected 0", wb_en); end
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL r0_bypass: got %h expected 0", rs_data); end
    tick(); idle(); rs_addr = 5'd0; #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL r0_read: got %h expected 0", rs_data); end
    n_cmp++; if (retired !== CW'(2)) begin n_err++; $display("FAIL r0_retired: got %0d expected 2", retired); end
    $display("test_r0_write: finished");
  endtask

  task automatic test_bypass();
    idle(); wb_in = 1'b1; reg_dest_in = 5'd9; alu_result_in = 32'hAA; rt_addr = 5'd9; rs_addr = 5'd9; #1;
    n_cmp++; if (rt_data !== 32'hAA) begin n_err++; $display("FAIL bypass_rt: got %h expected aa", rt_data); end
    n_cmp++; if (rs_data !== 32'hAA) begin n_err++; $display("FAIL bypass_rs: got %h expected aa", rs_data); end
    tick(); idle(); rt_addr = 5'd9; #1;
    n_cmp++; if (rt_data !== 32'hAA) begin n_err++; $display("FAIL bypass_stored: got %h expected aa", rt_data); end
    n_cmp++; if (retired !== CW'(3)) begin n_err++; $display("FAIL bypass_retired: got %0d expected 3", retired); end
    $display("test_bypass: finished");
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      wb_in = 1'($urandom_range(0, 3) != 0); mem_r_in = 1'($urandom_range(0, 1));
      mem_result_in = $urandom; alu_result_in = $urandom;
      reg_dest_in = 5'($urandom_range(0, 31)); terminate_in = 1'b0;
      rs_addr = ($urandom_range(0, 3) == 0) ? reg_dest_in : 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? reg_dest_in : 5'($urandom_range(0, 31));
      #1;
      n_cmp++; if (wb_en !== exp_wben()) begin n_err++; $display("FAIL rnd_wben: got %b expected %b", wb_en, exp_wben()); end
      n_cmp++; if (wb_data !== exp_wbdata()) begin n_err++; $display("FAIL rnd_wbdata: got %h expected %h", wb_data, exp_wbdata()); end
      n_cmp++; if (rs_data !== exp_read(rs_addr)) begin n_err++; $display("FAIL rnd_rs[%0d]: got %h expected %h", rs_addr, rs_data, exp_read(rs_addr)); end
      n_cmp++; if (rt_data !== exp_read(rt_addr)) begin n_err++; $display("FAIL rnd_rt[%0d]: got %h expected %h", rt_addr, rt_data, exp_read(rt_addr)); end
      n_cmp++; if (retired !== CW'(m_ret)) begin n_err++; $display("FAIL rnd_retired: got %0d expected %0d", retired, m_ret); end
      tick();
    end
    idle();
    $display("test_random: finished %0d cycles", n);
  endtask

  task automatic test_dump_scenario();
    pulse_reset();
    wb_in = 1'b1; alu_result_in = 32'h33; reg_dest_in = 5'd3; tick();
    idle(); terminate_in = 1'b1; tick();
    for (int k = 0; k < 32; k++) begin
      wb_in = 1'b1; reg_dest_in = 5'($urandom_range(1, 31)); alu_result_in = $urandom;
      terminate_in = 1'($urandom_range(0, 1)); rs_addr = 5'(k); #1;
      n_cmp++; if (dump_valid !== 1'b1) begin n_err++; $display("FAIL dump_valid beat %0d: got %b expected 1", k, dump_valid); end
      n_cmp++; if (dump_addr !== 5'(k)) begin n_err++; $display("FAIL dump_addr beat %0d: got %0d expected %0d", k, dump_addr, k); end
      n_cmp++; if (dump_data !== ((k == 3) ? 32'h33 : 32'h0)) begin n_err++; $display("FAIL dump_data beat %0d: got %h", k, dump_data); end
      n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL dump_wben beat %0d: got %b expected 0", k, wb_en); end
      n_cmp++; if (rs_data !== ((k == 3) ? 32'h33 : 32'h0)) begin n_err++; $display("FAIL dump_read beat %0d: got %h", k, rs_data); end
      n_cmp++; if (retired !== CW'(1)) begin n_err++; $display("FAIL dump_retired beat %0d: got %0d expected 1", k, retired); end
      tick();
    end
    idle(); #1;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_set: got %b expected 1", done); end
    n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL done_dump_valid: got %b expected 0", dump_valid); end
    n_cmp++; if (dump_addr !== 5'd0) begin n_err++; $display("FAIL done_dump_addr: got %0d expected 0", dump_addr); end
    n_cmp++; if (dump_data !== 32'h0) begin n_err++; $display("FAIL done_dump_data: got %h expected 0", dump_data); end
    wb_in = 1'b1; reg_dest_in = 5'd3; alu_result_in = 32'h44; rs_addr = 5'd3; #1;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL done_wben: got %b expected 0", wb_en); end
    n_cmp++; if (rs_data !== 32'h33) begin n_err++; $display("FAIL done_nobypass: got %h expected 33", rs_data); end
    tick(); idle(); tick(); tick(); rs_addr = 5'd3; #1;
    n_cmp++; if (rs_data !== 32'h33) begin n_err++; $display("FAIL done_r3_kept: got %h expected 33", rs_data); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_sticky: got %b expected 1", done); end
    n_cmp++; if (retired !== CW'(1)) begin n_err++; $display("FAIL done_retired: got %0d expected 1", retired); end
    $display("test_dump_scenario: finished");
  endtask

  task automatic test_terminate_with_write();
    logic [4:0] d;
    pulse_reset();
    test_random(12);
    d = 5'($urandom_range(1, 31));
    wb_in = 1'b1; reg_dest_in = d; alu_result_in = $urandom; terminate_in = 1'b1; tick();
    idle();
    for (int k = 0; k < 32; k++) begin
      #1;
      n_cmp++; if (dump_addr !== 5'(k)) begin n_err++; $display("FAIL tw_dump_addr beat %0d: got %0d", k, dump_addr); end
      n_cmp++; if (dump_data !== m_regs[k]) begin n_err++; $display("FAIL tw_dump_data beat %0d: got %h expected %h", k, dump_data, m_regs[k]); end
      tick();
    end
    #1;
    n_cmp++; if (retired !== CW'(m_ret)) begin n_err++; $display("FAIL tw_retired: got %0d expected %0d", retired, m_ret); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL tw_done: got %b expected 1", done); end
    $display("test_terminate_with_write: finished, last write r%0d", d);
  endtask

  task automatic test_reset_mid_dump();
    pulse_reset();
    test_random(10);
    terminate_in = 1'b1; tick(); idle();
    for (int k = 0; k < 10; k++) tick();
    #1;
    n_cmp++; if (dump_addr !== 5'd10) begin n_err++; $display("FAIL mid_beat: got %0d expected 10", dump_addr); end
    rst = 1'b1; wb_in = 1'b1; reg_dest_in = 5'd5; alu_result_in = 32'hBAD; tick();
    rst = 1'b0; idle(); #1;
    n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL mid_dump_valid: got %b expected 0", dump_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b expected 0", done); end
    n_cmp++; if (retired !== '0) begin n_err++; $display("FAIL mid_retired: got %0d expected 0", retired); end
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); #1;
      n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL mid_clear r%0d: got %h expected 0", a, rs_data); end
    end
    tick(); tick(); #1;
    n_cmp++; if (dump_valid !== 1'b0) begin n_err++; $display("FAIL mid_stays_run: got %b expected 0", dump_valid); end
    $display("test_reset_mid_dump: finished");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_state = 0; m_beat = 0; m_ret = 0;
    rst = 1'b1; idle(); rs_addr = '0; rt_addr = '0;
    test_reset();
    test_write_alu();
    test_load_select();
    test_r0_write();
    test_bypass();
    test_random(300);
    test_dump_scenario();
    test_terminate_with_write();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD (32), meaning data word width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the write-retire counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 SHALL provide ports, in this order:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 wb_in  in  1  write-back enable from the MEM/WB register
 mem_r_in  in  1  1 = select memory result, 0 = select ALU result
 mem_result_in  in  WIDTH  load data
 alu_result_in  in  WIDTH  ALU data
 reg_dest_in  in  5  destination register
 terminate_in  in  1  program-end marker
 rs_addr  in  5  read port A address
 rt_addr  in  5  read port B address
 rs_data  out  WIDTH  read port A data
 rt_data  out  WIDTH  read port B data
 wb_data  out  WIDTH  selected write-back value, for forwarding
 wb_en  out  1  qualified write strobe, for forwarding
 dump_valid  out  1  dump beat valid
 dump_addr  out  5  dump register index
 dump_data  out  WIDTH  dump register contents
 done  out  1  dump complete, sticky
 retired  out  CNT_W  count of register writes performed

Function
REQ-005 SHALL drive wb_data combinationally: mem_result_in when mem_r_in=1, else alu_result_in.
REQ-006 SHALL drive wb_en = wb_in AND reg_dest_in!=0 AND state==RUN AND !rst.
REQ-007 SHALL write wb_data into register[reg_dest_in] at the clk edge where wb_en=1; latency 1 cycle.
REQ-008 SHALL hold register 0 at zero; writes to register 0 SHALL be discarded and SHALL NOT count.
REQ-009 SHALL read rs_data/rt_data combinationally; address 0 SHALL return 0.
REQ-010 SHALL bypass: when wb_en=1 and a read address equals reg_dest_in (nonzero), that port SHALL return wb_data in the same cycle.
REQ-011 SHALL increment retired by 1 on each edge with wb_en=1, saturating at all-ones.
REQ-012 SHALL implement FSM states RUN, DUMP, DONE.
REQ-013 RUN -> DUMP on an edge with terminate_in=1; a write with wb_en=1 on that same edge SHALL still be performed and counted.
REQ-014 DUMP SHALL last exactly 32 cycles; in cycle k (k=0..31) dump_valid=1, dump_addr=k, dump_data=register[k] (post-write value).
REQ-015 DUMP -> DONE after the beat with dump_addr=31; DONE SHALL be held until rst.
REQ-016 In DUMP and DONE: wb_in, terminate_in SHALL be ignored; no writes; retired frozen; read ports remain functional without bypass.
REQ-017 done SHALL be 1 exactly when state==DONE; dump_valid SHALL be 1 only in DUMP.
REQ-018 dump_addr and dump_data SHALL be 0 when dump_valid=0.

Reset
REQ-019 On an edge with rst=1, all 32 registers SHALL clear to 0, state SHALL become RUN, retired=0, dump counter=0.
REQ-020 rst SHALL override any same-edge write or terminate_in; no write occurs on the reset edge.
REQ-021 rst asserted mid-DUMP SHALL abort the dump; dump_valid=0 on the following cycle.
REQ-022 After reset: rs_data=rt_data=0, dump_valid=0, done=0, retired=0.

Verification
REQ-023 Write r5: wb_in=1, mem_r_in=0, alu_result_in=0x1234, reg_dest_in=5 -> next cycle rs_addr=5 gives 0x1234, retired=1.
REQ-024 Load select: mem_r_in=1, mem_result_in=0xDEADBEEF, alu_result_in=0x1, reg_dest_in=7 -> r7=0xDEADBEEF.
REQ-025 r0 write: wb_in=1, reg_dest_in=0, data 0xFFFF -> rs_addr=0 reads 0, wb_en=0, retired unchanged.
REQ-026 Bypass: same cycle wb_en=1 to r9 with 0xAA, rt_addr=9 -> rt_data=0xAA before the edge.
REQ-027 Terminate after writing r3=0x33: 32 dump beats, beat 3 shows 0x33, others 0; then done=1; later wb_in=1 to r3 with 0x44 leaves r3=0x33.
REQ-028 Reset at dump beat 10 -> dump_valid=0, done=0, all registers read 0, retired=0.
